// File: rtl/frame_sched_pkg.sv
// Shared definitions for the frame scheduler and the receive state machine.
//
// Contents:
//   sched_state_e   - scheduler FSM states
//   *Def constants  - default frame geometry (also used by the receiver) and
//                     default arbitration/timeout settings
//   cnt_width()     - counter width helper that never returns zero
package frame_sched_pkg;

  localparam int unsigned NReqDef        = 4;
  localparam int unsigned FrameBytesDef  = 4;
  localparam int unsigned BitsPerByteDef = 8;
  localparam int unsigned TimeoutCycDef  = 64;

  typedef enum logic [2:0] {
    StIdle,
    StWaitRdy,
    StSend,
    StWaitFin,
    StDone,
    StAbort
  } sched_state_e;

  // Width needed to count 0..n-1; a single bit is kept for n <= 1 so that
  // degenerate parameterisations still elaborate.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_sched_rr_arbiter.sv
// Combinational requester selection for frame_sched.
//
// Default build: rotating priority. The search starts one past the previous
// winner (last_idx_i) and wraps, so every active requester is served within
// NReq frames.
// With FRAME_SCHED_FIXED_PRIO_EN defined: fixed priority, lowest index wins and
// last_idx_i is ignored.
//
// Ports:
//   req_i       - per-requester frame request
//   last_idx_i  - index of the requester that owned the previous frame
//   grant_o     - one-hot selected requester (all zero when any_o is low)
//   idx_o       - binary index of the selected requester
//   any_o       - at least one request is pending
module frame_sched_rr_arbiter
  import frame_sched_pkg::*;
#(
  parameter int unsigned NReq = NReqDef,
  parameter int unsigned IdxW = cnt_width(NReqDef)
) (
  input  logic [NReq-1:0] req_i,
  input  logic [IdxW-1:0] last_idx_i,
  output logic [NReq-1:0] grant_o,
  output logic [IdxW-1:0] idx_o,
  output logic            any_o
);

`ifdef FRAME_SCHED_FIXED_PRIO_EN

  logic unused_last_idx;
  assign unused_last_idx = ^last_idx_i;

  always_comb begin
    logic [IdxW-1:0] cand;
    cand    = '0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int unsigned i = 0; i < NReq; i++) begin
      cand = IdxW'(i);
      if (!any_o && req_i[cand]) begin
        any_o          = 1'b1;
        grant_o[cand]  = 1'b1;
        idx_o          = cand;
      end
    end
  end

`else

  always_comb begin
    logic [IdxW-1:0] cand;
    cand    = '0;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    // k = NReq revisits last_idx_i itself, so a lone requester can win twice
    // in a row.
    for (int unsigned k = 1; k <= NReq; k++) begin
      cand = IdxW'((32'(last_idx_i) + k) % NReq);
      if (!any_o && req_i[cand]) begin
        any_o          = 1'b1;
        grant_o[cand]  = 1'b1;
        idx_o          = cand;
      end
    end
  end

`endif

endmodule

// File: rtl/frame_sched.sv
// Frame scheduler: shares one serial TX->RX link between NReq requesters.
//
// A grant covers a whole frame of FrameBytes bytes, BitsPerByte bits each.
// Before every byte the block waits for rx_ready_i; after the last byte it
// waits for rx_finish_i. Either wait longer than TimeoutCyc cycles aborts
// the frame. Requests are only arbitrated while idle.
//
// Build option: FRAME_SCHED_FIXED_PRIO_EN selects fixed lowest-index-first
// priority instead of round-robin (see frame_sched_rr_arbiter).
//
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   req_i           - per-requester frame request (level)
//   req_data_i      - per-requester serial data bit
//   gnt_o           - registered one-hot grant, held for the whole frame
//   bit_ack_o       - one-hot, granted requester's bit consumed this cycle
//   tx_valid_o      - serial bit valid towards the receiver
//   tx_data_o       - serial bit, req_data_i of the granted requester
//   rx_ready_i      - receiver ready for the next byte
//   rx_finish_i     - receiver holds a complete frame
//   frame_done_o    - registered one-cycle pulse, frame completed
//   frame_err_o     - registered one-cycle pulse, frame aborted on timeout
//   busy_o          - high in every state except idle
module frame_sched
  import frame_sched_pkg::*;
#(
  parameter int unsigned NReq        = NReqDef,
  parameter int unsigned FrameBytes  = FrameBytesDef,
  parameter int unsigned BitsPerByte = BitsPerByteDef,
  parameter int unsigned TimeoutCyc  = TimeoutCycDef
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NReq-1:0] req_i,
  input  logic [NReq-1:0] req_data_i,
  output logic [NReq-1:0] gnt_o,
  output logic [NReq-1:0] bit_ack_o,
  output logic            tx_valid_o,
  output logic            tx_data_o,
  input  logic            rx_ready_i,
  input  logic            rx_finish_i,
  output logic            frame_done_o,
  output logic            frame_err_o,
  output logic            busy_o
);

  localparam int unsigned IdxW  = cnt_width(NReq);
  localparam int unsigned BitW  = cnt_width(BitsPerByte);
  localparam int unsigned ByteW = cnt_width(FrameBytes);
  localparam int unsigned ToW   = cnt_width(TimeoutCyc);

  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NReq - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(BitsPerByte - 1);
  localparam logic [ByteW-1:0] ByteLast = ByteW'(FrameBytes - 1);
  localparam logic [ToW-1:0]   ToLast   = ToW'(TimeoutCyc - 1);

  sched_state_e     state_q;
  logic [NReq-1:0]  gnt_q;
  logic [IdxW-1:0]  idx_q;
  logic [IdxW-1:0]  last_idx_q;
  logic [BitW-1:0]  bit_cnt_q;
  logic [ByteW-1:0] byte_cnt_q;
  logic [ToW-1:0]   to_cnt_q;
  logic             done_q;
  logic             err_q;

  logic [NReq-1:0]  arb_gnt;
  logic [IdxW-1:0]  arb_idx;
  logic             arb_any;
  logic             send;

  frame_sched_rr_arbiter #(
    .NReq (NReq),
    .IdxW (IdxW)
  ) u_arbiter (
    .req_i      (req_i),
    .last_idx_i (last_idx_q),
    .grant_o    (arb_gnt),
    .idx_o      (arb_idx),
    .any_o      (arb_any)
  );

  // gnt/done/err change together on the way into DONE/ABORT, so the pulse
  // and the released grant are visible in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      idx_q      <= '0;
      last_idx_q <= IdxLast;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      to_cnt_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (arb_any) begin
            gnt_q      <= arb_gnt;
            idx_q      <= arb_idx;
            byte_cnt_q <= '0;
            to_cnt_q   <= '0;
            state_q    <= StWaitRdy;
          end
        end
        StWaitRdy: begin
          if (rx_ready_i) begin
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
            state_q   <= StSend;
          end else if (to_cnt_q == ToLast) begin
            gnt_q   <= '0;
            err_q   <= 1'b1;
            state_q <= StAbort;
          end else begin
            to_cnt_q <= to_cnt_q + ToW'(1);
          end
        end
        StSend: begin
          // rx_ready_i is deliberately not looked at: a byte is never split.
          if (bit_cnt_q == BitLast) begin
            if (byte_cnt_q == ByteLast) begin
              state_q <= StWaitFin;
            end else begin
              byte_cnt_q <= byte_cnt_q + ByteW'(1);
              state_q    <= StWaitRdy;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + BitW'(1);
          end
        end
        StWaitFin: begin
          // to_cnt_q is already zero here: it was cleared entering StSend.
          if (rx_finish_i) begin
            gnt_q   <= '0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else if (to_cnt_q == ToLast) begin
            gnt_q   <= '0;
            err_q   <= 1'b1;
            state_q <= StAbort;
          end else begin
            to_cnt_q <= to_cnt_q + ToW'(1);
          end
        end
        StDone, StAbort: begin
          // An aborted requester also gives up priority, so a stuck source
          // cannot monopolise the link.
          last_idx_q <= idx_q;
          state_q    <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign send = (state_q == StSend);

  always_comb begin
    bit_ack_o = '0;
    if (send) begin
      bit_ack_o[idx_q] = 1'b1;
    end
  end

  assign tx_valid_o   = send;
  assign tx_data_o    = send & req_data_i[idx_q];
  assign gnt_o        = gnt_q;
  assign frame_done_o = done_q;
  assign frame_err_o  = err_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_frame_sched.sv
// Self-checking bench for frame_sched. Inputs are driven and outputs sampled
// on the falling clock edge; the DUT acts on the rising edge.
module tb_frame_sched;

  localparam int NReq        = 4;
  localparam int FrameBytes  = 4;
  localparam int BitsPerByte = 8;
  localparam int TimeoutCyc  = 64;
  localparam int FrameBits   = FrameBytes * BitsPerByte;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NReq-1:0] req, req_data, gnt, bit_ack;
  logic            tx_valid, tx_data, rx_ready, rx_finish;
  logic            frame_done, frame_err, busy;

  int checks = 0;
  int errors = 0;
  int model_last;

  frame_sched #(
    .NReq        (NReq),
    .FrameBytes  (FrameBytes),
    .BitsPerByte (BitsPerByte),
    .TimeoutCyc  (TimeoutCyc)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req),
    .req_data_i   (req_data),
    .gnt_o        (gnt),
    .bit_ack_o    (bit_ack),
    .tx_valid_o   (tx_valid),
    .tx_data_o    (tx_data),
    .rx_ready_i   (rx_ready),
    .rx_finish_i  (rx_finish),
    .frame_done_o (frame_done),
    .frame_err_o  (frame_err),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NReq-1:0] gnt_first;
    logic [NReq-1:0] gnt_end;
    int gnt_glitch;
    int bits;
    int acks;
    int bursts;
    int bad_burst;
    int data_err;
    int ack_err;
    int stall_valid;
    int resume_ok;
    int busy_low;
    int done;
    int err;
    int last_bit_cyc;
    int end_cyc;
    int ended;
    int after_active;
  } frame_obs_t;

  // Reference arbitration: who should own the link next.
  function automatic int model_pick(input logic [NReq-1:0] r, input int last);
`ifdef FRAME_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < NReq; i++) if (r[i]) return i;
`else
    for (int k = 1; k <= NReq; k++) if (r[(last + k) % NReq]) return (last + k) % NReq;
`endif
    return -1;
  endfunction

  function automatic logic [NReq-1:0] onehot(input int i);
    logic [NReq-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0; req = '0; req_data = '0; rx_ready = 1'b1; rx_finish = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_last = NReq - 1;
  endtask

  // Drives one frame from an idle DUT and records what the link did.
  // stall_after: bytes sent before a forced rx_ready stall (0 = none).
  // fin_delay: cycles after the last bit before rx_finish rises (<1 = never).
  // req_mode: 0 hold, 1 drop all requests after drop_bits bits, 2 random noise.
  task automatic run_frame(input logic [NReq-1:0] req_v, input int exp_idx,
                           input int stall_after, input int stall_len, input int fin_delay,
                           input int req_mode, input int drop_bits, output frame_obs_t o);
    int cyc, run, stall_left, rise_cyc;
    bit stalled;
    cyc = 0; run = 0; stall_left = 0; rise_cyc = -1; stalled = 0;
    o.gnt_first = '0; o.gnt_end = '0; o.gnt_glitch = 0; o.bits = 0; o.acks = 0;
    o.bursts = 0; o.bad_burst = 0; o.data_err = 0; o.ack_err = 0; o.stall_valid = 0;
    o.resume_ok = -1; o.busy_low = 0; o.done = 0; o.err = 0; o.last_bit_cyc = -1;
    o.end_cyc = -1; o.ended = 0; o.after_active = 0;
    req = req_v; req_data = NReq'($urandom); rx_ready = 1'b1; rx_finish = 1'b0;
    while (o.ended == 0 && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) o.gnt_first = gnt;
      if (busy !== 1'b1) o.busy_low++;
      if (tx_valid === 1'b1) begin
        o.bits++;
        run++;
        if (tx_data !== req_data[exp_idx]) o.data_err++;
        if (bit_ack[exp_idx] === 1'b1) o.acks++;
        if (bit_ack !== onehot(exp_idx)) o.ack_err++;
        if (stall_left > 0) o.stall_valid++;
        if (o.bits == FrameBits) o.last_bit_cyc = cyc;
      end else begin
        if (bit_ack !== '0) o.ack_err++;
        if (run > 0) begin
          o.bursts++;
          if (run != BitsPerByte) o.bad_burst++;
        end
        run = 0;
      end
      if (rise_cyc >= 0 && cyc == rise_cyc + 1) o.resume_ok = (tx_valid === 1'b1) ? 1 : 0;
      if (frame_done === 1'b1 || frame_err === 1'b1) begin
        o.done = (frame_done === 1'b1) ? 1 : 0;
        o.err = (frame_err === 1'b1) ? 1 : 0;
        o.end_cyc = cyc;
        o.gnt_end = gnt;
        o.ended = 1;
      end else if (cyc > 1 && gnt !== o.gnt_first) begin
        o.gnt_glitch++;
      end
      // Inputs for the next rising edge.
      req_data = NReq'($urandom);
      if (req_mode == 1 && o.bits >= drop_bits) req = '0;
      if (req_mode == 2) req = NReq'($urandom);
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) begin
          rx_ready = 1'b1;
          rise_cyc = cyc;
        end
      end else if (!stalled && stall_after > 0 && tx_valid === 1'b1 &&
                   o.bits == stall_after * BitsPerByte) begin
        rx_ready = 1'b0;
        stall_left = stall_len;
        stalled = 1;
      end else begin
        // While a byte is on the wire rx_ready must not matter.
        rx_ready = (tx_valid === 1'b1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (o.last_bit_cyc < 0) rx_finish = 1'($urandom_range(0, 1));
      else rx_finish = (fin_delay > 0 && cyc >= o.last_bit_cyc + fin_delay);
    end
    req = '0; rx_finish = 1'b0; rx_ready = 1'b1;
    @(negedge clk);
    o.after_active = (frame_done !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0 ||
                      gnt !== '0) ? 1 : 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '1; req_data = '1; rx_ready = 1'b1; rx_finish = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({gnt, bit_ack, tx_valid, tx_data, frame_done, frame_err, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b ack=%b v=%b d=%b done=%b err=%b busy=%b required 0",
               gnt, bit_ack, tx_valid, tx_data, frame_done, frame_err, busy);
    end
    req = '0; rx_finish = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || gnt !== '0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b gnt=%b required busy=0 gnt=0", busy, gnt);
    end
    model_last = NReq - 1;
  endtask

  task automatic test_single_frame();
    frame_obs_t o;
    int exp;
    exp = model_pick(4'b0010, model_last);
    run_frame(4'b0010, exp, 0, 0, 2, 0, 0, o);
    model_last = exp;
    checks++;
    if (o.gnt_first !== 4'b0010) begin
      errors++; $display("FAIL single_gnt: got %b required 0010", o.gnt_first);
    end
    checks++;
    if (o.bursts != FrameBytes || o.bad_burst != 0) begin
      errors++; $display("FAIL single_bursts: got %0d bursts %0d bad required %0d and 0",
                         o.bursts, o.bad_burst, FrameBytes);
    end
    checks++;
    if (o.data_err != 0 || o.bits != FrameBits) begin
      errors++; $display("FAIL single_data: got %0d bad of %0d bits required 0 of %0d",
                         o.data_err, o.bits, FrameBits);
    end
    checks++;
    if (o.done != 1 || o.err != 0 || o.end_cyc != o.last_bit_cyc + 3) begin
      errors++; $display("FAIL single_done: got done=%0d err=%0d at +%0d required 1,0 at +3",
                         o.done, o.err, o.end_cyc - o.last_bit_cyc);
    end
    checks++;
    if (o.gnt_end !== '0 || o.after_active != 0) begin
      errors++; $display("FAIL single_release: got gnt=%b lingering=%0d required 0000 and 0",
                         o.gnt_end, o.after_active);
    end
  endtask

  task automatic test_round_robin();
    frame_obs_t o;
    int exp;
    int order [5];
`ifdef FRAME_SCHED_FIXED_PRIO_EN
    order = '{0, 0, 0, 0, 0};
`else
    order = '{0, 1, 2, 3, 0};
`endif
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      exp = model_pick(4'b1111, model_last);
      run_frame(4'b1111, exp, 0, 0, 1, 0, 0, o);
      model_last = exp;
      checks++;
      if (o.gnt_first !== onehot(order[i]) || o.done != 1) begin
        errors++; $display("FAIL rr_order[%0d]: got gnt=%b done=%0d required %b and 1",
                           i, o.gnt_first, o.done, onehot(order[i]));
      end
    end
  endtask

  task automatic test_backpressure();
    frame_obs_t o;
    int exp;
    exp = model_pick(4'b1000, model_last);
    run_frame(4'b1000, exp, 2, 10, 1, 0, 0, o);
    model_last = exp;
    checks++;
    if (o.stall_valid != 0) begin
      errors++; $display("FAIL bp_stall: got %0d tx_valid cycles in stall required 0",
                         o.stall_valid);
    end
    checks++;
    if (o.resume_ok != 1) begin
      errors++; $display("FAIL bp_resume: got %0d required 1", o.resume_ok);
    end
    checks++;
    if (o.done != 1 || o.err != 0 || o.bursts != FrameBytes || o.bad_burst != 0) begin
      errors++; $display("FAIL bp_frame: got done=%0d err=%0d bursts=%0d bad=%0d required 1,0,%0d,0",
                         o.done, o.err, o.bursts, o.bad_burst, FrameBytes);
    end
  endtask

  task automatic test_timeout();
    frame_obs_t o;
    int exp, nxt;
    exp = model_pick(4'b0101, model_last);
    run_frame(4'b0101, exp, 0, 0, -1, 0, 0, o);
    model_last = exp;
    checks++;
    if (o.err != 1 || o.done != 0) begin
      errors++; $display("FAIL to_pulse: got err=%0d done=%0d required 1 and 0", o.err, o.done);
    end
    checks++;
    // Last bit at cycle L, WAIT_FIN entered at L+1, error TimeoutCyc later.
    if (o.end_cyc - (o.last_bit_cyc + 1) != TimeoutCyc) begin
      errors++; $display("FAIL to_latency: got %0d required %0d",
                         o.end_cyc - (o.last_bit_cyc + 1), TimeoutCyc);
    end
    checks++;
    if (o.gnt_end !== '0 || o.after_active != 0) begin
      errors++; $display("FAIL to_release: got gnt=%b lingering=%0d required 0000 and 0",
                         o.gnt_end, o.after_active);
    end
`ifdef FRAME_SCHED_FIXED_PRIO_EN
    nxt = 0;
`else
    nxt = (exp + 1) % NReq;
`endif
    run_frame(4'b1111, model_pick(4'b1111, model_last), 0, 0, 1, 0, 0, o);
    model_last = model_pick(4'b1111, model_last);
    checks++;
    if (o.gnt_first !== onehot(nxt) || o.done != 1) begin
      errors++; $display("FAIL to_next_gnt: got %b done=%0d required %b and 1",
                         o.gnt_first, o.done, onehot(nxt));
    end
  endtask

  task automatic test_req_drop();
    frame_obs_t o;
    int exp;
    exp = model_pick(4'b0100, model_last);
    run_frame(4'b0100, exp, 0, 0, 1, 1, 3, o);
    model_last = exp;
    checks++;
    if (o.acks != FrameBits || o.ack_err != 0) begin
      errors++; $display("FAIL drop_acks: got %0d acks %0d bad required %0d and 0",
                         o.acks, o.ack_err, FrameBits);
    end
    checks++;
    if (o.done != 1 || o.gnt_glitch != 0 || o.gnt_first !== 4'b0100) begin
      errors++; $display("FAIL drop_frame: got done=%0d glitch=%0d gnt=%b required 1,0,0100",
                         o.done, o.gnt_glitch, o.gnt_first);
    end
  endtask

  task automatic test_reset_mid_send();
    frame_obs_t o;
    int seen;
    apply_reset();
    req = 4'b0100; rx_ready = 1'b1; rx_finish = 1'b0; req_data = '1;
    seen = 0;
    for (int i = 0; i < 100 && seen < BitsPerByte + 3; i++) begin
      @(negedge clk);
      if (tx_valid === 1'b1) seen++;
    end
    checks++;
    if (seen < BitsPerByte + 3) begin
      errors++; $display("FAIL rst_reach_send: got %0d bits required %0d", seen, BitsPerByte + 3);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || gnt !== '0 || busy !== 1'b0 || bit_ack !== '0) begin
      errors++; $display("FAIL rst_async: got v=%b gnt=%b busy=%b ack=%b required all 0",
                         tx_valid, gnt, busy, bit_ack);
    end
    @(negedge clk);
    req = '0;
    rst_n = 1'b1;
    model_last = NReq - 1;
    @(negedge clk);
    run_frame(4'b1111, model_pick(4'b1111, model_last), 0, 0, 1, 0, 0, o);
    model_last = model_pick(4'b1111, model_last);
    checks++;
    if (o.gnt_first !== 4'b0001 || o.done != 1) begin
      errors++; $display("FAIL rst_priority: got %b done=%0d required 0001 and 1",
                         o.gnt_first, o.done);
    end
  endtask

  task automatic test_random();
    frame_obs_t o;
    logic [NReq-1:0] r;
    int exp, sa, sl, fd, mode;
    for (int n = 0; n < 12; n++) begin
      r = NReq'($urandom_range(1, (1 << NReq) - 1));
      exp = model_pick(r, model_last);
      sa = $urandom_range(0, FrameBytes - 1);
      sl = $urandom_range(1, 20);
      fd = $urandom_range(1, 5);
      mode = $urandom_range(0, 2);
      run_frame(r, exp, sa, sl, fd, mode, $urandom_range(0, FrameBits - 1), o);
      model_last = exp;
      checks++;
      if (o.gnt_first !== onehot(exp) || o.gnt_glitch != 0) begin
        errors++; $display("FAIL rand_gnt[%0d]: got %b glitch=%0d required %b (req %b)",
                           n, o.gnt_first, o.gnt_glitch, onehot(exp), r);
      end
      checks++;
      if (o.bursts != FrameBytes || o.bad_burst != 0 || o.acks != FrameBits) begin
        errors++; $display("FAIL rand_bursts[%0d]: got %0d bursts %0d bad %0d acks required %0d,0,%0d",
                           n, o.bursts, o.bad_burst, o.acks, FrameBytes, FrameBits);
      end
      checks++;
      if (o.data_err != 0 || o.ack_err != 0 || o.stall_valid != 0) begin
        errors++; $display("FAIL rand_data[%0d]: got data=%0d ack=%0d stall=%0d errors required 0",
                           n, o.data_err, o.ack_err, o.stall_valid);
      end
      checks++;
      if (o.done != 1 || o.err != 0 || o.end_cyc != o.last_bit_cyc + fd + 1 ||
          (sa > 0 && o.resume_ok != 1)) begin
        errors++; $display("FAIL rand_end[%0d]: got done=%0d err=%0d +%0d resume=%0d required 1,0,+%0d",
                           n, o.done, o.err, o.end_cyc - o.last_bit_cyc, o.resume_ok, fd + 1);
      end
      checks++;
      if (o.busy_low != 0 || o.gnt_end !== '0 || o.after_active != 0) begin
        errors++; $display("FAIL rand_busy[%0d]: got busy_low=%0d gnt_end=%b lingering=%0d required 0",
                           n, o.busy_low, o.gnt_end, o.after_active);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_req_drop();
    test_reset_mid_send();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
